// File: rtl/decoder_sched_pkg.sv
// Shared types, sizes and the round-robin pick function for the decoder scheduler.
package decoder_sched_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  // First set request bit scanning ptr, ptr+1, ... with wrap at N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dec4to16_en.sv
// 4-to-16 decoder with active-high enable, built from two levels of 2-to-4 decoders.
module dec4to16_en
  import decoder_sched_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] sel,
  output logic [N_REQ-1:0] dec
);

  function automatic logic [3:0] dec2to4(input logic e, input logic [1:0] a);
    return e ? (4'b0001 << a) : 4'b0000;
  endfunction

  logic [3:0] row_en;

  assign row_en = dec2to4(en, sel[3:2]);

  for (genvar g = 0; g < 4; g++) begin : g_col
    assign dec[4*g +: 4] = dec2to4(row_en[g], sel[1:0]);
  end

endmodule

// File: rtl/decoder_rr_scheduler.sv
// Round-robin owner scheduler for a shared 4-to-16 decoder with hold timeout
// and break-before-make gap cycles between owners.
module decoder_rr_scheduler
  import decoder_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] sel,
  output logic             sel_en,
  output logic [N_REQ-1:0] grant,
  output logic             timeout,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             sel_en_q, sel_en_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       gap_q, gap_d;
  logic             rel_w;
  logic             hold_hit_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      sel_en_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_en_q  <= sel_en_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    sel_en_d   = sel_en_q;
    timeout_d  = 1'b0;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    rel_w      = done | ~req[sel_q];
    hold_hit_w = (hold_q == 8'(MAX_HOLD));

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d    = rr_pick(req, ptr_q);
          sel_en_d = 1'b1;
          busy_d   = 1'b1;
          hold_d   = 8'd1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A release on the same edge as the hold limit wins, so no timeout pulse.
        if (rel_w || hold_hit_w) begin
          sel_en_d  = 1'b0;
          ptr_d     = sel_q + 4'd1;
          timeout_d = ~rel_w;
          gap_d     = 4'd1;
          state_d   = GAP;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == 4'(GAP_CYCLES)) begin
          if (|req) begin
            sel_d    = rr_pick(req, ptr_q);
            sel_en_d = 1'b1;
            hold_d   = 8'd1;
            state_d  = GRANT;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dec4to16_en u_dec (
    .en  (sel_en_q),
    .sel (sel_q),
    .dec (grant)
  );

  assign sel     = sel_q;
  assign sel_en  = sel_en_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Directed self-checking bench for decoder_rr_scheduler (MAX_HOLD=8, GAP_CYCLES=1).
module tb_decoder_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic        sel_en;
  logic [15:0] grant;
  logic        timeout;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  decoder_rr_scheduler #(
    .MAX_HOLD   (8),
    .GAP_CYCLES (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .sel_en  (sel_en),
    .grant   (grant),
    .timeout (timeout),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_sel, input logic e_en,
                            input logic [15:0] e_grant, input logic e_to, input logic e_busy);
    check({tag, ".sel"},     32'(sel),     32'(e_sel));
    check({tag, ".sel_en"},  32'(sel_en),  32'(e_en));
    check({tag, ".grant"},   32'(grant),   32'(e_grant));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    check({tag, ".busy"},    32'(busy),    32'(e_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (2) tick();
    expect_out("reset", 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  idx;
    logic [15:0] g;

    // Single requester
    do_reset();
    req = 16'h0010;
    tick(); expect_out("single.grant", 4'd4, 1'b1, 16'h0010, 1'b0, 1'b1);
    tick();
    tick(); expect_out("single.hold", 4'd4, 1'b1, 16'h0010, 1'b0, 1'b1);
    done = 1'b1;
    tick(); expect_out("single.gap", 4'd4, 1'b0, 16'h0000, 1'b0, 1'b1);
    done = 1'b0; req = '0;
    tick(); expect_out("single.idle", 4'd4, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Round-robin wrap between 0 and 15
    do_reset();
    req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      idx = (k % 2 == 0) ? 4'd0 : 4'd15;
      g   = 16'h0001 << idx;
      tick(); expect_out("wrap.grant", idx, 1'b1, g, 1'b0, 1'b1);
      done = 1'b1;
      tick(); expect_out("wrap.gap", idx, 1'b0, 16'h0000, 1'b0, 1'b1);
      done = 1'b0;
    end
    req = '0;
    tick(); expect_out("wrap.idle", 4'd15, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Hold timeout
    do_reset();
    req = 16'h0100;
    tick();
    for (int k = 0; k < 8; k++) begin
      expect_out("tmo.held", 4'd8, 1'b1, 16'h0100, 1'b0, 1'b1);
      tick();
    end
    expect_out("tmo.revoke", 4'd8, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick(); expect_out("tmo.regrant", 4'd8, 1'b1, 16'h0100, 1'b0, 1'b1);

    // done coincides with hold limit: release, no timeout
    repeat (7) tick();
    done = 1'b1;
    tick(); expect_out("coinc.gap", 4'd8, 1'b0, 16'h0000, 1'b0, 1'b1);
    done = 1'b0;
    tick(); expect_out("coinc.regrant", 4'd8, 1'b1, 16'h0100, 1'b0, 1'b1);
    req = 16'h0101;
    tick(); expect_out("nonowner.ignored", 4'd8, 1'b1, 16'h0100, 1'b0, 1'b1);
    req = 16'h0001;
    tick(); expect_out("reqdrop.release", 4'd8, 1'b0, 16'h0000, 1'b0, 1'b1);
    req = '0;
    tick(); expect_out("reqdrop.idle", 4'd8, 1'b0, 16'h0000, 1'b0, 1'b0);
    done = 1'b1;
    tick(); expect_out("idle.done", 4'd8, 1'b0, 16'h0000, 1'b0, 1'b0);
    done = 1'b0;
    tick(); expect_out("idle.after", 4'd8, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset mid-grant; leaves ptr=6 first so a stale ptr would pick 6
    req = 16'h0020;
    tick(); expect_out("rst.grant5", 4'd5, 1'b1, 16'h0020, 1'b0, 1'b1);
    done = 1'b1;
    tick(); expect_out("rst.gap", 4'd5, 1'b0, 16'h0000, 1'b0, 1'b1);
    done = 1'b0;
    tick(); expect_out("rst.regrant5", 4'd5, 1'b1, 16'h0020, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 expect_out("rst.async", 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
    req = 16'h0060;
    tick();
    #3 rst_n = 1'b1;
    tick(); expect_out("rst.first", 4'd5, 1'b1, 16'h0020, 1'b0, 1'b1);

    // Full fairness sweep
    do_reset();
    req = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      g   = 16'h0001 << idx;
      tick(); expect_out("fair.grant", idx, 1'b1, g, 1'b0, 1'b1);
      done = 1'b1;
      tick(); expect_out("fair.gap", idx, 1'b0, 16'h0000, 1'b0, 1'b1);
      done = 1'b0;
    end
    req = '0;
    tick(); expect_out("fair.idle", 4'd15, 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
